// File: rtl/fp_special_result.sv
// Result-side special-case merge for the FMA: queues issue-time classifier flags and
// overrides the datapath result with qNaN/Inf/zero/C when needed. Optional status via FP_SPEC_STATUS_EN.
module fp_special_result #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 23,
  parameter int DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  output logic             iss_ready,
  input  logic             iss_a_pz,
  input  logic             iss_a_nz,
  input  logic             iss_b_pz,
  input  logic             iss_b_nz,
  input  logic             iss_c_pz,
  input  logic             iss_c_nz,
  input  logic             iss_nan,
  input  logic             iss_pinf,
  input  logic             iss_ninf,
  input  logic             iss_prod_sign,
  input  logic [WIDTH-1:0] iss_c,
  input  logic             dp_valid,
  output logic             dp_ready,
  input  logic [WIDTH-1:0] dp_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_special,
`ifdef FP_SPEC_STATUS_EN
  output logic [2:0]       out_exc,
`endif
  output logic             err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] PINF = {1'b0, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
  localparam logic [WIDTH-1:0] NINF = {1'b1, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};

  // Entry layout: {nan, pinf, ninf, a_pz, a_nz, b_pz, b_nz, c_pz, c_nz, prod_sign}
  logic [9:0]       flagMem [DEPTH];
  logic [WIDTH-1:0] cMem    [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W:0]   count;
  logic [9:0]       headFlags;
  logic [WIDTH-1:0] headC;
  logic             push, pop, outFree;

  // Returns {special, result}; first matching case wins.
  function automatic logic [WIDTH:0] forceResult(input logic [9:0] f,
                                                 input logic [WIDTH-1:0] c,
                                                 input logic [WIDTH-1:0] dp);
    logic prodZero, cZero;
    prodZero = |f[6:3];
    cZero    = f[2] | f[1];
    if (f[9] | (f[8] & f[7])) return {1'b1, QNAN};
    if (f[8])                 return {1'b1, PINF};
    if (f[7])                 return {1'b1, NINF};
    if (prodZero && cZero)    return {1'b1, f[0] & f[1], {(WIDTH-1){1'b0}}};
    if (prodZero)             return {1'b1, c};
    return {1'b0, dp};
  endfunction

`ifdef FP_SPEC_STATUS_EN
  // {invalid, inf, zero} classification of the same priority chain.
  function automatic logic [2:0] excFlags(input logic [9:1] f);
    logic invalid, inf;
    invalid = f[9] | (f[8] & f[7]);
    inf     = ~invalid & (f[8] | f[7]);
    return {invalid, inf, ~invalid & ~inf & (|f[6:3]) & (f[2] | f[1])};
  endfunction
`endif

  assign iss_ready = (count != FULL_CNT);
  assign outFree   = ~out_valid | out_ready;
  assign dp_ready  = (count != '0) & outFree;
  assign push      = iss_valid & iss_ready;
  assign pop       = dp_valid & dp_ready;
  assign headFlags = flagMem[rdPtr];
  assign headC     = cMem[rdPtr];

  // Issue stage: flag storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push) begin
      flagMem[wrPtr] <= {iss_nan, iss_pinf, iss_ninf, iss_a_pz, iss_a_nz,
                         iss_b_pz, iss_b_nz, iss_c_pz, iss_c_nz, iss_prod_sign};
      cMem[wrPtr]    <= iss_c;
    end
  end

  // Merge stage: queue control and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      wrPtr       <= '0;
      rdPtr       <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_special <= 1'b0;
      err         <= 1'b0;
`ifdef FP_SPEC_STATUS_EN
      out_exc     <= 3'b000;
`endif
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
      if (dp_valid && count == '0) err <= 1'b1;
      if (pop) begin
        out_valid                 <= 1'b1;
        {out_special, out_result} <= forceResult(headFlags, headC, dp_result);
`ifdef FP_SPEC_STATUS_EN
        out_exc                   <= excFlags(headFlags[9:1]);
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_special_result.sv
// Directed bench for fp_special_result: special-case priority, queue full/order/wrap,
// protocol error and reset behaviour. Checks out_exc too when FP_SPEC_STATUS_EN is defined.
module tb_fp_special_result;
  localparam int WIDTH = 32;

  localparam logic [9:0] F_NONE = 10'b0000000000;
  localparam logic [9:0] F_NAN  = 10'b1000000000;
  localparam logic [9:0] F_PINF = 10'b0100000000;
  localparam logic [9:0] F_NINF = 10'b0010000000;
  localparam logic [9:0] F_ANZ  = 10'b0000100000;
  localparam logic [9:0] F_BPZ  = 10'b0000010000;
  localparam logic [9:0] F_CPZ  = 10'b0000000100;
  localparam logic [9:0] F_CNZ  = 10'b0000000010;
  localparam logic [9:0] F_PS   = 10'b0000000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iss_valid = 1'b0;
  logic iss_ready;
  logic iss_a_pz = 1'b0, iss_a_nz = 1'b0, iss_b_pz = 1'b0, iss_b_nz = 1'b0;
  logic iss_c_pz = 1'b0, iss_c_nz = 1'b0, iss_nan = 1'b0, iss_pinf = 1'b0;
  logic iss_ninf = 1'b0, iss_prod_sign = 1'b0;
  logic [WIDTH-1:0] iss_c = '0;
  logic dp_valid = 1'b0;
  logic dp_ready;
  logic [WIDTH-1:0] dp_result = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [WIDTH-1:0] out_result;
  logic out_special;
  logic err;
`ifdef FP_SPEC_STATUS_EN
  logic [2:0] out_exc;
`endif

  int nTests = 0;
  int nFail  = 0;

  logic [WIDTH-1:0] fillC   [4];
  logic [9:0]       fillF   [4];
  logic [WIDTH-1:0] fillDp  [4];
  logic [WIDTH-1:0] fillExp [4];

  fp_special_result #(.WIDTH(32), .EXP_WIDTH(8), .SIG_WIDTH(23), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_a_pz(iss_a_pz), .iss_a_nz(iss_a_nz), .iss_b_pz(iss_b_pz), .iss_b_nz(iss_b_nz),
    .iss_c_pz(iss_c_pz), .iss_c_nz(iss_c_nz), .iss_nan(iss_nan), .iss_pinf(iss_pinf),
    .iss_ninf(iss_ninf), .iss_prod_sign(iss_prod_sign), .iss_c(iss_c),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_result(dp_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_special(out_special),
`ifdef FP_SPEC_STATUS_EN
    .out_exc(out_exc),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %b, expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkExc(input string tag, input logic [2:0] exp);
`ifdef FP_SPEC_STATUS_EN
    nTests++;
    assert (out_exc === exp) else begin
      nFail++;
      $error("FAIL %s: observed out_exc %b, expected %b", tag, out_exc, exp);
    end
`else
    if (exp === 3'bxxx) $display("unused %s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setIss(input logic [9:0] f, input logic [WIDTH-1:0] c);
    {iss_nan, iss_pinf, iss_ninf, iss_a_pz, iss_a_nz,
     iss_b_pz, iss_b_nz, iss_c_pz, iss_c_nz, iss_prod_sign} = f;
    iss_c = c;
  endtask

  task automatic issueOne(input logic [9:0] f, input logic [WIDTH-1:0] c);
    setIss(f, c);
    iss_valid = 1'b1;
    tick();
    iss_valid = 1'b0;
    setIss(F_NONE, '0);
  endtask

  // Presents one datapath result with out_ready=1, checks the merged output, then lets it drain.
  task automatic mergeOne(input string tag, input logic [WIDTH-1:0] dp,
                          input logic [WIDTH-1:0] expRes, input logic expSpec,
                          input logic [2:0] expExc);
    dp_valid  = 1'b1;
    dp_result = dp;
    #1;
    checkBit({tag, "_dp_ready"}, dp_ready, 1'b1);
    tick();
    dp_valid = 1'b0;
    checkBit({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_result"}, out_result, expRes);
    checkBit({tag, "_special"}, out_special, expSpec);
    checkExc({tag, "_exc"}, expExc);
    tick();
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checkBit("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 32'h0);
    checkBit("rst_out_special", out_special, 1'b0);
    checkBit("rst_err", err, 1'b0);
    checkBit("rst_iss_ready", iss_ready, 1'b1);
    checkBit("rst_dp_ready", dp_ready, 1'b0);
    checkExc("rst_exc", 3'b000);

    // Plain datapath passthrough, then drop of out_valid after acceptance
    issueOne(F_NONE, 32'h3F800000);
    mergeOne("normal", 32'h40400000, 32'h40400000, 1'b0, 3'b000);
    checkBit("normal_drop", out_valid, 1'b0);

    // Special-case priority
    issueOne(F_PINF | F_NINF, 32'h3F800000);
    mergeOne("inf_minus_inf", 32'h12345678, 32'h7FC00000, 1'b1, 3'b100);
    issueOne(F_NAN | F_ANZ | F_CPZ, 32'h0);
    mergeOne("nan_over_zero", 32'h12345678, 32'h7FC00000, 1'b1, 3'b100);
    issueOne(F_PINF | F_BPZ, 32'h0);
    mergeOne("pinf", 32'h12345678, 32'h7F800000, 1'b1, 3'b010);
    issueOne(F_NINF, 32'h3F800000);
    mergeOne("ninf", 32'h12345678, 32'hFF800000, 1'b1, 3'b010);
    issueOne(F_ANZ | F_CNZ | F_PS, 32'h80000000);
    mergeOne("neg_zero", 32'h12345678, 32'h80000000, 1'b1, 3'b001);
    issueOne(F_ANZ | F_CPZ | F_PS, 32'h00000000);
    mergeOne("pos_zero", 32'h12345678, 32'h00000000, 1'b1, 3'b001);
    issueOne(F_BPZ, 32'hC0A00000);
    mergeOne("c_pass", 32'h12345678, 32'hC0A00000, 1'b1, 3'b000);

    // Fill to full with the consumer stalled; a 5th issue must be refused
    fillF[0] = F_NONE; fillC[0] = 32'h0;        fillDp[0] = 32'h11111111; fillExp[0] = 32'h11111111;
    fillF[1] = F_PINF; fillC[1] = 32'h0;        fillDp[1] = 32'h22222222; fillExp[1] = 32'h7F800000;
    fillF[2] = F_BPZ;  fillC[2] = 32'h40490FDB; fillDp[2] = 32'h33333333; fillExp[2] = 32'h40490FDB;
    fillF[3] = F_NONE; fillC[3] = 32'h0;        fillDp[3] = 32'h44444444; fillExp[3] = 32'h44444444;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      setIss(fillF[i], fillC[i]);
      iss_valid = 1'b1;
      tick();
    end
    checkBit("full_iss_ready", iss_ready, 1'b0);
    setIss(F_NAN, 32'hDEADBEEF);
    tick();
    iss_valid = 1'b0;
    setIss(F_NONE, '0);
    checkBit("full_refused", iss_ready, 1'b0);

    // First result enters the output register and is held while stalled
    dp_valid  = 1'b1;
    dp_result = fillDp[0];
    #1;
    checkBit("stall_dp_ready0", dp_ready, 1'b1);
    tick();
    checkBit("stall_valid", out_valid, 1'b1);
    check("stall_result0", out_result, fillExp[0]);
    dp_result = fillDp[1];
    #1;
    checkBit("stall_dp_ready_blocked", dp_ready, 1'b0);
    tick();
    checkBit("hold_valid", out_valid, 1'b1);
    check("hold_result", out_result, fillExp[0]);
    checkBit("hold_iss_ready", iss_ready, 1'b1);

    // Release: back-to-back results in issue order
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      dp_result = fillDp[i];
      tick();
      checkBit("drain_valid", out_valid, 1'b1);
      check("drain_result", out_result, fillExp[i]);
    end
    dp_valid = 1'b0;
    #1;
    checkBit("drain_empty_dp_ready", dp_ready, 1'b0);
    checkBit("drain_no_err", err, 1'b0);
    tick();
    checkBit("drain_done", out_valid, 1'b0);

    // Ten operations with simultaneous push and pop each cycle; pointers wrap repeatedly
    for (int k = 0; k <= 10; k++) begin
      if (k < 10) begin
        setIss((k % 3 == 0) ? F_BPZ : F_NONE, (k % 3 == 0) ? (32'h40000000 + k) : 32'h0);
        iss_valid = 1'b1;
      end else begin
        iss_valid = 1'b0;
        setIss(F_NONE, '0);
      end
      if (k > 0) begin
        dp_valid  = 1'b1;
        dp_result = 32'h3F000000 + k - 1;
      end
      tick();
      if (k > 0) begin
        checkBit("wrap_valid", out_valid, 1'b1);
        check("wrap_result", out_result,
              ((k - 1) % 3 == 0) ? (32'h40000000 + k - 1) : (32'h3F000000 + k - 1));
      end
    end
    dp_valid = 1'b0;
    checkBit("wrap_empty_dp_ready", dp_ready, 1'b0);
    tick();

    // Protocol error: result with nothing queued
    dp_valid  = 1'b1;
    dp_result = 32'hAAAAAAAA;
    #1;
    checkBit("err_dp_ready", dp_ready, 1'b0);
    tick();
    dp_valid = 1'b0;
    checkBit("err_set", err, 1'b1);
    checkBit("err_no_valid", out_valid, 1'b0);
    tick();
    checkBit("err_sticky", err, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkBit("err_cleared", err, 1'b0);
    checkBit("err_rst_iss_ready", iss_ready, 1'b1);

    // Reset with a held output and three queued entries
    out_ready = 1'b0;
    issueOne(F_PINF, 32'h0);
    dp_valid  = 1'b1;
    dp_result = 32'h55555555;
    tick();
    dp_valid = 1'b0;
    setIss(F_NONE, 32'h0);
    iss_valid = 1'b1;
    tick();
    tick();
    tick();
    iss_valid = 1'b0;
    checkBit("pre_rst_held", out_valid, 1'b1);
    check("pre_rst_result", out_result, 32'h7F800000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkBit("mid_rst_out_valid", out_valid, 1'b0);
    checkBit("mid_rst_iss_ready", iss_ready, 1'b1);
    checkBit("mid_rst_dp_ready", dp_ready, 1'b0);
    check("mid_rst_result", out_result, 32'h0);
    checkBit("mid_rst_special", out_special, 1'b0);
    checkExc("mid_rst_exc", 3'b000);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/fp_special_result.md
Name: fp_special_result

Overview:
- Result-side counterpart of the FMA special-case classifier.
- Captures the classifier flags at operation issue and queues them in order.
- When the arithmetic datapath returns each result, combines the queued flags with it and emits the final IEEE-754 word, either the datapath value or a forced special (qNaN, ±Inf, ±0, C passthrough), over a valid/ready interface.
- Sits between the FMA datapath output and the FP writeback.

Parameters:
- WIDTH, 32, total FP width (32 or 64).
- EXP_WIDTH, 8, exponent field width.
- SIG_WIDTH, 23, stored significand width.
- DEPTH, 4, flag-queue entries; power of 2, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- iss_valid  input  1  operation issued this cycle.
- iss_ready  output  1  flag queue can accept an entry.
- iss_a_pz, iss_a_nz, iss_b_pz, iss_b_nz, iss_c_pz, iss_c_nz  input  1 each  ±zero flags for A, B, C.
- iss_nan  input  1  result must be NaN. Upstream folds operand NaN and Inf×0 into this flag.
- iss_pinf  input  1  some operand is +Inf.
- iss_ninf  input  1  some operand is −Inf.
- iss_prod_sign  input  1  sign(A) XOR sign(B).
- iss_c  input  WIDTH  operand C.
- dp_valid  input  1  datapath result available.
- dp_ready  output  1  datapath result consumed this cycle.
- dp_result  input  WIDTH  datapath result; returned in issue order.
- out_valid  output  1  final result valid.
- out_ready  input  1  consumer accepts.
- out_result  output  WIDTH  final result.
- out_special  output  1  result was forced by flags.
- err  output  1  sticky protocol error.

Behaviour:
Reset:
- Values after rst: queue empty (count=0, pointers=0), out_valid=0, out_result=0, out_special=0, err=0, iss_ready=1, dp_ready=0.
- rst mid-operation discards all queued entries and any held output.

Flag queue:
- Push when iss_valid & iss_ready.
- iss_ready = (count != DEPTH), derived from registered count only. No combinational path from dp_* or out_ready.
- Each entry holds the 9 zero/NaN/Inf flags, iss_prod_sign and iss_c.
- Read/write pointers are log2(DEPTH) bits and wrap naturally.

Merge:
- Output register is free when out_valid=0 or out_ready=1.
- dp_ready = (count != 0) & output register free.
- On dp_valid & dp_ready: pop the head entry, compute the result (priority below), load the output register and set out_valid=1. Latency is 1 cycle from accepted dp_valid to out_valid.
- Simultaneous push and pop: count unchanged and both take effect. At full, the push is still refused that cycle even if a pop occurs.
- out_valid and out_result hold stable while out_valid & ~out_ready.
- out_valid falls the cycle after acceptance unless a new merge occurs in the same cycle (back-to-back, one result per cycle).

Result priority (first match wins):
1. nan | (pinf & ninf) -> qNaN = {0, all-ones exponent, 1, zeros}: 0x7FC00000 (W=32), 0x7FF8000000000000 (W=64).
2. pinf -> {0, all-ones exponent, zeros}.
3. ninf -> {1, all-ones exponent, zeros}.
4. product zero (any of a_pz, a_nz, b_pz, b_nz) and C zero -> signed zero, sign = prod_sign & c_nz (round-to-nearest rule).
5. product zero, C nonzero -> the queued iss_c.
- Cases 1–5 set out_special=1.
- Otherwise out_result = dp_result and out_special=0.

Error:
- dp_valid while count==0 sets err=1. The datapath result is ignored and dp_ready stays 0.
- err clears only on rst.

Optional Feature:
- Macro FP_SPEC_STATUS_EN.
- When defined: adds output out_exc [2:0] = {invalid, inf, zero}, registered alongside out_result.
  - invalid = case 1.
  - inf = case 2 or 3.
  - zero = case 4.
  - Reset value 0; held stable with out_result.
- When undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset, then issue all-zero flags with iss_c=0x3F800000; dp_result=0x40400000 -> one cycle later out_valid=1, out_result=0x40400000, out_special=0.
- Issue pinf=1 and ninf=1 -> out_result=0x7FC00000, out_special=1 (out_exc=3'b100 when enabled).
- Issue a_nz=1, c_nz=1, prod_sign=1 -> 0x80000000. Issue a_nz=1, c_pz=1, prod_sign=1 -> 0x00000000. Issue b_pz=1, iss_c=0xC0A00000 -> 0xC0A00000.
- Issue 4 entries with out_ready=0 -> iss_ready=0 after the 4th push and a 5th iss_valid is not accepted. Then hold out_ready=1 with dp_valid continuous -> results appear in order, one per cycle; pointer wrap verified over 10 operations.
- dp_valid=1 with empty queue -> err=1, dp_ready=0, no out_valid. Assert rst -> err=0, queue empty.
- Assert rst with 3 entries queued and out_valid held -> next cycle out_valid=0, iss_ready=1, dp_ready=0.
